i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  I2C target (responder) that answers board-management transactions from an i2c_master.
//  Presents a small byte-wide register file to an external I2C bus: write pointer, then data.
//  Sits beside the management I2C master on the 50 MHz clock domain.
//  Exposes register contents and write strobes to fabric logic, e.g. SFP/PHY control bits.
// PARAMETERS
//  DEV_ADDR   7'h50  7-bit I2C address this target responds to
//  REG_COUNT  8      number of 8-bit registers; pointer wraps modulo REG_COUNT (power of 2)
//  FILTER_LEN 4      consecutive equal samples needed to accept a new SCL/SDA level
// PORTS
//  clk         in   1            system clock (clk_50mhz)
//  rst         in   1            asynchronous active-high reset
//  scl_i       in   1            SCL pin level
//  scl_o       out  1            SCL drive value; constant 1'b1
//  scl_t       out  1            SCL tristate; constant 1'b1 (no clock stretching)
//  sda_i       in   1            SDA pin level
//  sda_o       out  1            SDA drive value; constant 1'b0
//  sda_t       out  1            SDA tristate; 0 pulls SDA low, 1 releases it
//  regs_out    out  8*REG_COUNT  flattened register file; reg k is at [8k+7:8k]
//  wr_strobe   out  1            1-cycle pulse when a data byte is committed
//  wr_index    out  log2(REG_COUNT)  register index of the last committed write
//  busy        out  1            high between an addressed START and the following STOP
// BEHAVIOUR
//  Reset values:
//   - sda_t=1; regs_out=0; wr_strobe=0; wr_index=0; busy=0; pointer=0; state=IDLE.
//  Input conditioning:
//   - scl_i and sda_i each pass a 2-FF synchroniser, then the glitch filter.
//   - The filtered level changes only after FILTER_LEN equal consecutive samples.
//   - Edges are detected on filtered signals: scl_rise, scl_fall.
//   - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
//  Bit timing:
//   - SDA is sampled on scl_rise; shift register is MSB first.
//   - sda_t changes only on the cycle after scl_fall, never while SCL is high.
//  State machine:
//   - IDLE: wait for START.
//   - ADDR: shift 8 bits. If the address matches DEV_ADDR -> ACK_ADDR, else -> IDLE.
//     A non-matching target keeps sda_t=1 throughout.
//   - ACK_ADDR: drive SDA low for the 9th clock.
//     R/W=0 -> WR_PTR; R/W=1 -> RD_DATA (first byte is regs[pointer]).
//   - WR_PTR: shift 8 bits; pointer <= byte mod REG_COUNT; -> ACK_PTR (ACK) -> WR_DATA.
//   - WR_DATA: shift 8 bits -> ACK_DATA.
//   - ACK_DATA: commit on the scl_rise of the 8th bit.
//     regs[pointer] <= byte, wr_strobe pulses, wr_index=pointer, pointer++ (wrap).
//     Drive the ACK, then -> WR_DATA.
//   - RD_DATA: load regs[pointer] into the shift register on entry.
//     Drive bit7..bit0 (bit=0 -> sda_t=0, bit=1 -> sda_t=1); pointer++ after bit0.
//     Then release SDA -> RD_ACK.
//   - RD_ACK: sample the master ACK on scl_rise.
//     ACK (0) -> RD_DATA with the next register; NACK (1) -> IDLE (SDA released).
//  Bus conditions:
//   - Repeated START in any state -> ADDR, sda_t=1; the pointer is kept.
//   - STOP in any state -> IDLE, sda_t=1, busy=0.
//   - A partial byte is discarded with no commit.
//   - busy rises on the ACK_ADDR entry and falls on STOP, or on entering IDLE after NACK.
//   - General call (address 0) is not acknowledged.
//  Timing and reset:
//   - wr_strobe latency: exactly 1 clk after the filtered scl_rise of data bit0.
//   - The pointer persists across transactions; only rst clears it.
//   - rst mid-transfer releases SDA immediately (asynchronously).
// TESTING
//  - Write 0x50+W, ptr 0x02, data 0xA5, STOP:
//    -> ACK on all 3 bytes; regs[2]=0xA5; one wr_strobe with wr_index=2.
//  - Write ptr 0x07, data 0x11,0x22:
//    -> regs[7]=0x11, regs[0]=0x22 (wrap); two strobes, indices 7 then 0.
//  - Preload regs[3]=0x3C, regs[4]=0xC3. Write ptr 3, repeated START, 0x50+R, read 2 bytes (ACK, NACK):
//    -> returns 0x3C, 0xC3; SDA released after NACK; busy=0 after STOP.
//  - Address 0x51+W:
//    -> no ACK (sda_t=1 for all 9 clocks); regs unchanged; busy stays 0.
//  - 2-cycle SDA glitch while SCL high, FILTER_LEN=4:
//    -> no START/STOP detected; state unchanged.
//  - Assert rst during data bit 4 of a write:
//    -> sda_t=1 same cycle; regs=0; the next full transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a REG_COUNT x 8 register file (pointer byte, then auto-incrementing data bytes).
// wr_strobe lands 1 clk after the filtered SCL rise of data bit0; no backpressure, SCL is never stretched.

// Two-flop synchroniser followed by a level filter: the output follows the input only
// after FILTER_LEN consecutive samples disagree with the current output.
module i2c_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dout  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         REG_COUNT  = 8,
    parameter int         FILTER_LEN = 4,
    localparam int        PW         = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl_i,
    output logic                   scl_o,
    output logic                   scl_t,
    input  logic                   sda_i,
    output logic                   sda_o,
    output logic                   sda_t,
    output logic [8*REG_COUNT-1:0] regs_out,
    output logic                   wr_strobe,
    output logic [PW-1:0]          wr_index,
    output logic                   busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_WR_PTR, S_ACK_PTR,
        S_WR_DATA, S_ACK_DATA, S_RD_DATA, S_RD_ACK
    } state_t;

    state_t state, state_nxt;

    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]                  bit_cnt;
    logic                        rose;
    logic [7:0]                  sreg;
    logic                        rw_q;
    logic [PW-1:0]               ptr;
    logic [REG_COUNT-1:0][7:0]   regs;
    logic                        sda_t_q;
    logic                        busy_q;
    logic                        wr_strobe_q;
    logic [PW-1:0]               wr_index_q;

    logic [7:0] rx_byte, rd_byte;
    logic       last_bit, addr_match;

    logic sda_t_d, shift_in, commit, ptr_load, ptr_inc, rd_load, busy_set, busy_clr;

    assign scl_o    = 1'b1;
    assign scl_t    = 1'b1;
    assign sda_o    = 1'b0;
    assign sda_t    = sda_t_q;
    assign busy     = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index = wr_index_q;
    assign regs_out = regs;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_flt (.clk(clk), .rst(rst), .din(scl_i), .dout(scl_f));
    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_flt (.clk(clk), .rst(rst), .din(sda_i), .dout(sda_f));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    assign rx_byte    = {sreg[6:0], sda_f};
    assign rd_byte    = regs[ptr];
    assign last_bit   = scl_rise && (bit_cnt == 4'd7);
    // General call (address 0) is never acknowledged, whatever DEV_ADDR is set to.
    assign addr_match = (rx_byte[7:1] == DEV_ADDR) && (rx_byte[7:1] != 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ACK slots end on the SCL fall that follows the 9th rise (tracked by rose).
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = S_IDLE;
        end else if (start_det) begin
            state_nxt = S_ADDR;
        end else begin
            unique case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_ADDR:     if (last_bit) state_nxt = addr_match ? S_ACK_ADDR : S_IDLE;
                S_ACK_ADDR: if (scl_fall && rose) state_nxt = rw_q ? S_RD_DATA : S_WR_PTR;
                S_WR_PTR:   if (last_bit) state_nxt = S_ACK_PTR;
                S_ACK_PTR:  if (scl_fall && rose) state_nxt = S_WR_DATA;
                S_WR_DATA:  if (last_bit) state_nxt = S_ACK_DATA;
                S_ACK_DATA: if (scl_fall && rose) state_nxt = S_WR_DATA;
                S_RD_DATA:  if (scl_fall && bit_cnt == 4'd8) state_nxt = S_RD_ACK;
                S_RD_ACK: begin
                    if (scl_rise && sda_f)     state_nxt = S_IDLE;
                    else if (scl_fall && rose) state_nxt = S_RD_DATA;
                end
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sda_t_d  = sda_t_q;
        shift_in = 1'b0;
        commit   = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        rd_load  = 1'b0;
        busy_set = 1'b0;
        busy_clr = 1'b0;
        if (stop_det) begin
            sda_t_d  = 1'b1;
            busy_clr = 1'b1;
        end else if (start_det) begin
            sda_t_d = 1'b1;
        end else begin
            unique case (state)
                S_ADDR: begin
                    shift_in = scl_rise;
                    busy_set = last_bit && addr_match;
                end
                S_WR_PTR: begin
                    shift_in = scl_rise;
                    ptr_load = last_bit;
                end
                S_WR_DATA: begin
                    shift_in = scl_rise;
                    commit   = last_bit;
                end
                S_ACK_ADDR, S_ACK_PTR, S_ACK_DATA: begin
                    // First fall pulls SDA low, the fall after the 9th rise releases it.
                    if (scl_fall) sda_t_d = rose;
                    if (state == S_ACK_ADDR && scl_fall && rose && rw_q) begin
                        rd_load = 1'b1;
                        sda_t_d = rd_byte[7];
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t_d = 1'b1;
                            ptr_inc = 1'b1;
                        end else begin
                            sda_t_d = sreg[~bit_cnt[2:0]];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && sda_f) begin
                        busy_clr = 1'b1;
                    end else if (scl_fall && rose) begin
                        rd_load = 1'b1;
                        sda_t_d = rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            rose        <= 1'b0;
            sreg        <= '0;
            rw_q        <= 1'b0;
            ptr         <= '0;
            regs        <= '0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            // Every state entry (and a repeated START) restarts the bit count,
            // which also drops any partially shifted byte.
            if (state_nxt != state || start_det) begin
                bit_cnt <= '0;
                rose    <= 1'b0;
            end else if (scl_rise) begin
                bit_cnt <= bit_cnt + 4'd1;
                rose    <= 1'b1;
            end

            if (rd_load)       sreg <= rd_byte;
            else if (shift_in) sreg <= rx_byte;

            if (state == S_ADDR && last_bit) rw_q <= sda_f;

            if (ptr_load)               ptr <= rx_byte[PW-1:0];
            else if (commit || ptr_inc) ptr <= ptr + 1'b1;

            if (commit) begin
                regs[ptr]  <= rx_byte;
                wr_index_q <= ptr;
            end
            wr_strobe_q <= commit;

            if (busy_clr)      busy_q <= 1'b0;
            else if (busy_set) busy_q <= 1'b1;

            sda_t_q <= sda_t_d;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master against the register-file target.
module tb_i2c_slave_regfile;
    localparam int Q = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_o, scl_t, sda_o, sda_t, wr_strobe, busy;
    logic [63:0] regs_out;
    logic [2:0]  wr_index;
    wire         sda_line = sda_m & sda_t;

    int n_vec = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int low_cnt = 0;
    logic [2:0] idx_log [$];

    always #10 clk = ~clk;

    i2c_slave_regfile #(.DEV_ADDR(7'h50), .REG_COUNT(8), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_m), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_line), .sda_o(sda_o), .sda_t(sda_t),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            idx_log.push_back(wr_index);
        end
        if (!sda_t) low_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_at(input int i);
        return (i < idx_log.size()) ? int'(idx_log[i]) : -1;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    // One SCL period; optional 2-cycle opposite-level pulse on SDA while SCL is high.
    task automatic clk_bit(input logic b, input logic glitch, output logic s);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q / 2);
        if (glitch) begin
            sda_m = ~b; wait_clk(2);
            sda_m = b;  wait_clk(Q / 2 - 2);
        end else begin
            wait_clk(Q / 2);
        end
        s = sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch, s);
        clk_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clk_bit(ack_bit, 1'b0, s);
    endtask

    task automatic wr_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                          input int n, input logic glitch, input string tag);
        logic ack;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack); check_val({tag, "_ack_addr"}, ack, 1'b1);
        send_byte(p, 1'b0, ack);     check_val({tag, "_ack_ptr"}, ack, 1'b1);
        send_byte(d0, glitch, ack);  check_val({tag, "_ack_d0"}, ack, 1'b1);
        if (n > 1) begin
            send_byte(d1, glitch, ack); check_val({tag, "_ack_d1"}, ack, 1'b1);
        end
        check_val({tag, "_busy"}, busy, 1'b1);
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] a;
        int         lc;

        wait_clk(5);
        check_val("rst_sda_t", sda_t, 1'b1);
        check_val("rst_regs", regs_out, 64'h0);
        check_val("rst_strobe", wr_strobe, 1'b0);
        check_val("rst_index", wr_index, 3'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("const_pins", {scl_o, scl_t, sda_o}, 3'b110);
        rst = 1'b0;
        wait_clk(5);

        // Single write.
        wr_txn(8'h02, 8'hA5, 8'h00, 1, 1'b0, "t1");
        check_val("t1_regs", regs_out, 64'h0000_0000_00A5_0000);
        check_val("t1_strobes", strobe_cnt, 1);
        check_val("t1_idx", idx_at(0), 2);
        check_val("t1_busy_stop", busy, 1'b0);

        // Pointer wrap.
        wr_txn(8'h07, 8'h11, 8'h22, 2, 1'b0, "t2");
        check_val("t2_regs", regs_out, 64'h1100_0000_00A5_0022);
        check_val("t2_strobes", strobe_cnt, 3);
        check_val("t2_idx0", idx_at(1), 7);
        check_val("t2_idx1", idx_at(2), 0);

        // Preload then read back through a repeated START.
        wr_txn(8'h03, 8'h3C, 8'hC3, 2, 1'b0, "t3p");
        check_val("t3_regs", regs_out, 64'h1100_00C3_3CA5_0022);
        i2c_start();
        send_byte(8'hA0, 1'b0, ack); check_val("t3_ack_addr", ack, 1'b1);
        send_byte(8'h03, 1'b0, ack); check_val("t3_ack_ptr", ack, 1'b1);
        i2c_start();
        send_byte(8'hA1, 1'b0, ack); check_val("t3_ack_rd", ack, 1'b1);
        recv_byte(1'b0, d);          check_val("t3_rd0", d, 8'h3C);
        recv_byte(1'b1, d);          check_val("t3_rd1", d, 8'hC3);
        check_val("t3_released", sda_t, 1'b1);
        check_val("t3_busy_nack", busy, 1'b0);
        i2c_stop();
        check_val("t3_busy_stop", busy, 1'b0);

        // Pointer survives a STOP.
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h04, 1'b0, ack);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, 1'b0, ack); check_val("t3b_ack_rd", ack, 1'b1);
        recv_byte(1'b1, d);          check_val("t3b_rd", d, 8'hC3);
        i2c_stop();

        // Wrong address and general call are ignored.
        lc = low_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b0, ack); check_val("t4_nack", ack, 1'b0);
        check_val("t4_busy", busy, 1'b0);
        send_byte(8'h55, 1'b0, ack);
        i2c_stop();
        i2c_start();
        send_byte(8'h00, 1'b0, ack); check_val("t4_gc_nack", ack, 1'b0);
        i2c_stop();
        check_val("t4_sda_never_low", low_cnt - lc, 0);
        check_val("t4_regs", regs_out, 64'h1100_00C3_3CA5_0022);
        check_val("t4_strobes", strobe_cnt, 5);

        // Short SDA pulses while SCL is high must not look like START/STOP.
        wr_txn(8'h05, 8'h5A, 8'h00, 1, 1'b1, "t5");
        check_val("t5_regs", regs_out, 64'h1100_5AC3_3CA5_0022);
        check_val("t5_strobes", strobe_cnt, 6);
        check_val("t5_idx", idx_at(5), 5);

        // Reset while the target is driving the address ACK.
        a = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) clk_bit(a[i], 1'b0, s);
        sda_m = 1'b1; wait_clk(Q);
        check_val("t6_ack_driven", sda_t, 1'b0);
        rst = 1'b1;
        #1;
        check_val("t6_rst_release", sda_t, 1'b1);
        check_val("t6_rst_regs", regs_out, 64'h0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        i2c_stop();
        wr_txn(8'h06, 8'h77, 8'h00, 1, 1'b0, "t6");
        check_val("t6_regs", regs_out, 64'h0077_0000_0000_0000);

        // Reset during data bit 4 of a write.
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h01, 1'b0, ack);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0, s);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q / 2);
        rst = 1'b1;
        #1;
        check_val("t7_sda_t", sda_t, 1'b1);
        check_val("t7_regs", regs_out, 64'h0);
        check_val("t7_busy", busy, 1'b0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        i2c_stop();
        check_val("t7_strobes", strobe_cnt, 7);
        wr_txn(8'h01, 8'h42, 8'h00, 1, 1'b0, "t7");
        check_val("t7_regs_after", regs_out, 64'h0000_0000_0000_4200);
        check_val("t7_idx", idx_at(7), 1);
        check_val("t7_strobes_after", strobe_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
